// File: rtl/w5300_bus_engine.sv
// w5300_bus_engine: timed bus master for the W5300 direct-address parallel interface
// Optional feature macro: W5300_ADDR_INC_EN (burst beats step the address by DATA_W/8;
// when undefined every beat reuses cmd_addr, for FIFO-register access).
// Ports:
//   clk0, rst_n (sync, active-low)          clock and reset
//   cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_len   command handshake
//   wr_data/wr_valid/wr_ready               write beat stream
//   rd_data/rd_valid                        read beat stream
//   busy, irq                               status, synchronised interrupt
//   data, int_n, addr, cs_n, rd_n, we_n, reset_n, rw_n   W5300 pins
module w5300_bus_engine #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 5,
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 1,
    parameter int T_RST    = 64
) (
    input  logic              clk0,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              irq,
    inout  wire  [DATA_W-1:0] data,
    input  logic              int_n,
    output logic [ADDR_W-1:0] addr,
    output logic              cs_n,
    output logic              rd_n,
    output logic              we_n,
    output logic              reset_n,
    output logic              rw_n
);
    localparam int T_MAX = (T_SETUP > T_STROBE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                                : ((T_STROBE > T_HOLD) ? T_STROBE : T_HOLD);
    localparam int PH_W = $clog2(T_MAX) + 1;
    localparam int RC_W = $clog2(T_RST) + 1;
    typedef enum logic [2:0] {S_RST, S_IDLE, S_GAP, S_SETUP, S_STROBE, S_HOLD} state_t;
    state_t            state;
    logic [PH_W-1:0]   ph;
    logic [RC_W-1:0]   rcnt;
    logic [LEN_W-1:0]  beats;
    logic              is_wr;
    logic              drive;
    logic [DATA_W-1:0] dout;
    logic              int_s1;
    assign data = drive ? dout : {DATA_W{1'bz}};
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            state     <= S_RST;
            ph        <= '0;
            rcnt      <= '0;
            beats     <= '0;
            is_wr     <= 1'b0;
            drive     <= 1'b0;
            dout      <= '0;
            addr      <= '0;
            cs_n      <= 1'b1;
            rd_n      <= 1'b1;
            we_n      <= 1'b1;
            rw_n      <= 1'b1;
            reset_n   <= 1'b0;
            cmd_ready <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            rd_data   <= '0;
        end else begin
            wr_ready <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                S_RST: begin
                    if (rcnt == RC_W'(T_RST - 1)) begin
                        reset_n   <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        rcnt <= rcnt + RC_W'(1);
                    end
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        is_wr     <= cmd_we;
                        addr      <= cmd_addr;
                        beats     <= cmd_len;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    // writes stall here with cs_n high until a data beat is offered
                    if (!is_wr || wr_valid) begin
                        cs_n  <= 1'b0;
                        ph    <= '0;
                        state <= S_SETUP;
                        if (is_wr) begin
                            dout     <= wr_data;
                            drive    <= 1'b1;
                            rw_n     <= 1'b0;
                            wr_ready <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (ph == PH_W'(T_SETUP - 1)) begin
                        ph    <= '0;
                        rd_n  <= is_wr;
                        we_n  <= !is_wr;
                        state <= S_STROBE;
                    end else begin
                        ph <= ph + PH_W'(1);
                    end
                end
                S_STROBE: begin
                    if (ph == PH_W'(T_STROBE - 1)) begin
                        ph    <= '0;
                        rd_n  <= 1'b1;
                        we_n  <= 1'b1;
                        state <= S_HOLD;
                        if (!is_wr) begin
                            rd_data  <= data;
                            rd_valid <= 1'b1;
                        end
                    end else begin
                        ph <= ph + PH_W'(1);
                    end
                end
                S_HOLD: begin
                    if (ph == PH_W'(T_HOLD - 1)) begin
                        ph    <= '0;
                        cs_n  <= 1'b1;
                        drive <= 1'b0;
                        rw_n  <= 1'b1;
                        if (beats != '0) begin
                            beats <= beats - LEN_W'(1);
`ifdef W5300_ADDR_INC_EN
                            addr  <= addr + ADDR_W'(DATA_W / 8);
`else
                            addr  <= addr;
`endif
                            state <= S_GAP;
                        end else begin
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else begin
                        ph <= ph + PH_W'(1);
                    end
                end
                default: state <= S_RST;
            endcase
        end
    end
    // two-flop synchroniser; irq itself is the second stage
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            int_s1 <= 1'b1;
            irq    <= 1'b0;
        end else begin
            int_s1 <= int_n;
            irq    <= !int_s1;
        end
    end
endmodule

// File: tb/tb_w5300_bus_engine.sv
// tb_w5300_bus_engine: self-checking bench for w5300_bus_engine at default parameters
module tb_w5300_bus_engine;
    logic        clk0 = 1'b0;
    logic        rst_n, cmd_valid, cmd_we, wr_valid, int_n;
    logic [9:0]  cmd_addr;
    logic [4:0]  cmd_len;
    logic [15:0] wr_data;
    logic        cmd_ready, wr_ready, rd_valid, busy, irq, cs_n, rd_n, we_n, reset_n, rw_n;
    logic [15:0] rd_data;
    logic [9:0]  addr;
    wire  [15:0] data;
    always #5 clk0 = ~clk0;
    w5300_bus_engine dut (
        .clk0(clk0), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .irq(irq), .data(data), .int_n(int_n), .addr(addr), .cs_n(cs_n),
        .rd_n(rd_n), .we_n(we_n), .reset_n(reset_n), .rw_n(rw_n)
    );
    logic [15:0] rmem [1024];
    logic [15:0] wdata [32];
    assign data = (!cs_n && !rd_n) ? rmem[addr] : 16'bz;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int slen = 0;
    int rw_bad = 0;
    logic pwe = 1'b1, prd = 1'b1, pcs = 1'b1;
    logic [25:0] wr_log [$];
    logic [9:0]  rd_log [$];
    logic [15:0] rd_out [$];
    int          stb_len [$];
    int          cs_fall [$];
    always @(negedge clk0) begin
        cyc++;
        if (!we_n && pwe) wr_log.push_back({addr, data});
        if (!rd_n && prd) rd_log.push_back(addr);
        if (!rd_n && !rw_n) rw_bad++;
        if (!we_n || !rd_n) slen++;
        else if (!pwe || !prd) begin
            stb_len.push_back(slen);
            slen = 0;
        end
        if (!cs_n && pcs) cs_fall.push_back(cyc);
        if (rd_valid) rd_out.push_back(rd_data);
        pwe = we_n;
        prd = rd_n;
        pcs = cs_n;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [9:0] beat_addr(input logic [9:0] a, input int i);
`ifdef W5300_ADDR_INC_EN
        return a + 10'(i * 2);
`else
        return a + 10'(i * 0);
`endif
    endfunction
    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        rd_out.delete();
        stb_len.delete();
        cs_fall.delete();
        rw_bad = 0;
    endtask
    task automatic count_reset();
        int n = 0;
        int bad = 0;
        while (reset_n === 1'b0 && n < 200) begin
            if (cmd_ready !== 1'b0 || cs_n !== 1'b1 || busy !== 1'b0) bad++;
            n++;
            @(negedge clk0);
        end
        chk("reset_len", n, 64);
        chk("ready_after_reset", cmd_ready, 1);
        chk("pins_during_reset", bad, 0);
    endtask
    task automatic run_cmd(input logic we, input logic [9:0] a, input int len,
                           input int stall_at, input int stall_n);
        int n;
        @(negedge clk0);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_len   = 5'(len);
        wr_valid  = we && (stall_at != 0);
        wr_data   = wdata[0];
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk0);
            n++;
        end
        chk("accept_timeout", n < 100, 1);
        @(negedge clk0);
        cmd_valid = 1'b0;
        if (we) begin
            for (int i = 0; i <= len; i++) begin
                if (i == stall_at) begin
                    wr_valid = 1'b0;
                    n = 0;
                    do begin @(negedge clk0); n++; end while (cs_n !== 1'b1 && n < 50);
                    for (int s = 0; s < stall_n; s++) begin
                        @(negedge clk0);
                        chk("stall_cs_n", cs_n, 1);
                    end
                end
                wr_valid = 1'b1;
                wr_data  = wdata[i];
                n = 0;
                do begin @(negedge clk0); n++; end while (wr_ready !== 1'b1 && n < 50);
                chk("wr_ready_timeout", wr_ready, 1);
            end
            wr_valid = 1'b0;
        end
        n = 0;
        do begin @(negedge clk0); n++; end while (busy !== 1'b0 && n < 500);
        chk("idle_timeout", busy, 0);
        @(negedge clk0);
    endtask
    task automatic check_cmd(input logic we, input logic [9:0] a, input int len);
        logic [9:0] ea;
        chk("beat_count", we ? wr_log.size() : rd_log.size(), len + 1);
        chk("strobe_count", stb_len.size(), len + 1);
        chk("rw_n_during_read", rw_bad, 0);
        for (int i = 0; i <= len; i++) begin
            ea = beat_addr(a, i);
            if (i < stb_len.size()) chk("strobe_len", stb_len[i], 4);
            if (we && i < wr_log.size()) begin
                chk("wr_addr", wr_log[i][25:16], ea);
                chk("wr_data", wr_log[i][15:0], wdata[i]);
            end
            if (!we && i < rd_log.size()) chk("rd_addr", rd_log[i], ea);
            if (!we && i < rd_out.size()) chk("rd_data", rd_out[i], rmem[ea]);
            if (!we && i > 0 && i < cs_fall.size()) chk("beat_period", cs_fall[i] - cs_fall[i-1], 7);
        end
        if (!we) chk("rd_valid_count", rd_out.size(), len + 1);
        clear_logs();
    endtask
    initial begin
        int n;
        logic we;
        logic [9:0] a;
        int len;
        logic v;
        logic ih [$];
        for (int i = 0; i < 1024; i++) rmem[i] = 16'($urandom);
        rmem[10'h208] = 16'hA5C3;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; int_n = 1'b1;
        repeat (3) @(posedge clk0);
        @(negedge clk0);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_rd_n", rd_n, 1);
        chk("rst_we_n", we_n, 1);
        chk("rst_rw_n", rw_n, 1);
        chk("rst_reset_n", reset_n, 0);
        chk("rst_addr", addr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_flags", {cmd_ready, wr_ready, rd_valid, busy, irq}, 0);
        rst_n = 1'b1;
        count_reset();
        clear_logs();
        // single read
        run_cmd(1'b0, 10'h208, 0, 99, 0);
        chk("single_rd_data_pin", rd_data, 16'hA5C3);
        check_cmd(1'b0, 10'h208, 0);
        // write burst with a stalled third beat
        wdata[0] = 16'h1111; wdata[1] = 16'h2222; wdata[2] = 16'h3333; wdata[3] = 16'h4444;
        run_cmd(1'b1, 10'h22E, 3, 2, 5);
        check_cmd(1'b1, 10'h22E, 3);
        // wrap at top of address space
        run_cmd(1'b0, 10'h3FE, 1, 99, 0);
        check_cmd(1'b0, 10'h3FE, 1);
        // randomized commands
        for (int c = 0; c < 24; c++) begin
            we  = 1'($urandom_range(0, 1));
            a   = 10'($urandom_range(0, 1023));
            len = $urandom_range(0, 3);
            for (int i = 0; i <= len; i++) wdata[i] = 16'($urandom);
            run_cmd(we, a, len, $urandom_range(0, len + 1), $urandom_range(1, 3));
            check_cmd(we, a, len);
        end
        // reset during a write strobe
        wdata[0] = 16'hBEEF;
        @(negedge clk0);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h100; cmd_len = '0;
        wr_valid = 1'b1; wr_data = wdata[0];
        @(negedge clk0);
        cmd_valid = 1'b0;
        n = 0;
        while (we_n !== 1'b0 && n < 50) begin @(negedge clk0); n++; end
        chk("mid_we_low", we_n, 0);
        chk("mid_rw_low", rw_n, 0);
        rst_n = 1'b0;
        @(negedge clk0);
        wr_valid = 1'b0;
        chk("mid_we_n", we_n, 1);
        chk("mid_cs_n", cs_n, 1);
        chk("mid_rw_n", rw_n, 1);
        chk("mid_reset_n", reset_n, 0);
        chk("mid_busy", busy, 0);
        rst_n = 1'b1;
        count_reset();
        clear_logs();
        // interrupt: one-cycle pulse then a ten-cycle low
        ih.push_back(1'b1);
        ih.push_back(1'b1);
        for (int k = 0; k < 28; k++) begin
            @(negedge clk0);
            chk("irq", irq, !ih[k]);
            v = !(k == 3 || (k >= 8 && k < 18));
            int_n = v;
            ih.push_back(v);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
